// File: rtl/miner_pkg.sv
// Shared encodings for the miner job controller: FSM states, engine control/status
// bit positions and default pad bytes.
package miner_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        STOP   = 3'd4,
        REPORT = 3'd5
    } state_t;

    localparam int RUN_BIT   = 0;
    localparam int TEST_BIT  = 1;
    localparam int PADL_LSB  = 2;
    localparam int PADL_MSB  = 9;
    localparam int PADF_LSB  = 10;
    localparam int PADF_MSB  = 17;

    localparam int STAT_IRQ  = 0;
    localparam int STAT_RUN  = 1;
    localparam int STAT_TEST = 2;

    localparam logic [7:0]  DEF_PAD_FIRST     = 8'h06;
    localparam logic [7:0]  DEF_PAD_LAST      = 8'h80;
    localparam int          DEF_STOP_HOLD     = 4;
    localparam int          DEF_EXHAUST_SLACK = 8;
    localparam logic [31:0] DEF_WDOG_CYCLES   = 32'd100_000_000;

endpackage

// File: rtl/miner_nonce_budget.sv
// Nonce budget tracker: latches start/count per job and flags when the engine's
// solution counter has run past the budget plus pipeline slack (modular, wrap-safe).
module miner_nonce_budget
    import miner_pkg::*;
#(
    parameter int EXHAUST_SLACK = DEF_EXHAUST_SLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] start_nonce,
    input  logic [63:0] nonce_count,
    input  logic [63:0] solution,
    output logic        exhausted
);

    logic [63:0] start_q;
    logic [63:0] count_q;
    logic [63:0] progress;
    logic [64:0] limit;

    // Modular distance from the start nonce, so a wrap past 2^64-1 is counted correctly.
    assign progress = solution - start_q;
    assign limit    = {1'b0, count_q} + 65'(EXHAUST_SLACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= '0;
            count_q   <= '0;
            exhausted <= 1'b0;
        end else if (load) begin
            start_q   <= start_nonce;
            count_q   <= nonce_count;
            exhausted <= 1'b0;
        end else begin
            exhausted <= (count_q != 64'd0) && ({1'b0, progress} >= limit);
        end
    end

endmodule

// File: rtl/miner_job_ctrl.sv
// Job sequencer for one sha3_256 mining engine: job in, run low/high/low, one result out.
// Optional build macro MINER_WATCHDOG_EN adds a RUN-state cycle limit (res_timeout).
module miner_job_ctrl
    import miner_pkg::*;
#(
    parameter logic [7:0]  PAD_FIRST     = DEF_PAD_FIRST,
    parameter logic [7:0]  PAD_LAST      = DEF_PAD_LAST,
    parameter int          STOP_HOLD     = DEF_STOP_HOLD,
    parameter int          EXHAUST_SLACK = DEF_EXHAUST_SLACK,
    parameter logic [31:0] WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] job_header,
    input  logic [255:0] job_difficulty,
    input  logic [63:0]  job_start_nonce,
    input  logic [63:0]  job_nonce_count,
    input  logic         job_test,
    input  logic [7:0]   job_id,
    input  logic         abort,
    output logic [255:0] m_header,
    output logic [255:0] m_difficulty,
    output logic [63:0]  m_start_nonce,
    output logic [17:0]  m_control,
    input  logic [63:0]  m_solution,
    input  logic [2:0]   m_status,
    input  logic         m_irq,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [7:0]   res_id,
    output logic         res_found,
    output logic [63:0]  res_nonce,
    output logic         res_aborted,
    output logic         res_timeout,
    output logic         busy,
    output state_t       dbg_state
);

    // Handshakes: a transfer happens on the rising clk edge where valid & ready are both 1;
    // the producer holds valid and its data stable until that edge.

    localparam logic [7:0] HOLD_LAST = 8'(STOP_HOLD - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       run_q;
    logic       test_q;
    logic       exhausted;
    logic       wdog_hit;
    logic       accept;

    assign accept    = job_valid && job_ready;
    assign job_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign m_control = {PAD_FIRST, PAD_LAST, test_q, run_q};

`ifdef MINER_WATCHDOG_EN
    logic [31:0] wdog_cnt;
    assign wdog_hit = (wdog_cnt == WDOG_CYCLES - 32'd1);
    logic unused_ok;
    assign unused_ok = ^{m_status[STAT_TEST], m_status[STAT_IRQ]};
`else
    assign wdog_hit = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{m_status[STAT_TEST], m_status[STAT_IRQ], WDOG_CYCLES};
`endif

    miner_nonce_budget #(.EXHAUST_SLACK(EXHAUST_SLACK)) u_budget (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (accept),
        .start_nonce (job_start_nonce),
        .nonce_count (job_nonce_count),
        .solution    (m_solution),
        .exhausted   (exhausted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            run_q         <= 1'b0;
            test_q        <= 1'b0;
            m_header      <= '0;
            m_difficulty  <= '0;
            m_start_nonce <= '0;
            res_valid     <= 1'b0;
            res_id        <= '0;
            res_found     <= 1'b0;
            res_nonce     <= '0;
            res_aborted   <= 1'b0;
            res_timeout   <= 1'b0;
`ifdef MINER_WATCHDOG_EN
            wdog_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_header      <= job_header;
                        m_difficulty  <= job_difficulty;
                        m_start_nonce <= job_start_nonce;
                        test_q        <= job_test;
                        res_id        <= job_id;
                        res_found     <= 1'b0;
                        res_aborted   <= 1'b0;
                        res_timeout   <= 1'b0;
                        hold_cnt      <= '0;
                        state         <= LOAD;
                    end
                end
                LOAD, ARM: begin
                    if (abort) begin
                        run_q       <= 1'b0;
                        res_aborted <= 1'b1;
                        res_nonce   <= m_solution;
                        hold_cnt    <= '0;
                        state       <= STOP;
                    end else if (state == LOAD) begin
                        // Run held low long enough for the engine to load start_nonce.
                        if (hold_cnt == HOLD_LAST) begin
                            run_q <= 1'b1;
                            state <= ARM;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end else if (m_status[STAT_RUN]) begin
`ifdef MINER_WATCHDOG_EN
                        wdog_cnt <= '0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef MINER_WATCHDOG_EN
                    wdog_cnt <= wdog_cnt + 32'd1;
`endif
                    if (m_irq || abort || wdog_hit || exhausted) begin
                        run_q     <= 1'b0;
                        hold_cnt  <= '0;
                        res_nonce <= m_solution;
                        state     <= STOP;
                        if (m_irq)        res_found   <= 1'b1;
                        else if (abort)   res_aborted <= 1'b1;
                        else if (wdog_hit) res_timeout <= 1'b1;
                    end
                end
                STOP: begin
                    run_q <= 1'b0;
                    if (hold_cnt != 8'hFF) hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt >= HOLD_LAST && !m_status[STAT_RUN]) begin
                        res_valid <= 1'b1;
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/miner_job_ctrl.md
Name: miner_job_ctrl

Overview:
Job sequencer in front of one sha3_256 mining engine. Accepts jobs over a valid/ready handshake: header, difficulty, start nonce, nonce budget and job id. Drives the engine's header/difficulty/start_nonce/control inputs and sequences run low→high→low. Watches irq and solution, then returns one result per job (found / exhausted / aborted) over a valid/ready handshake toward the HPS register bridge.

Parameters:
PAD_FIRST, 8'h06, front pad byte driven on control[17:10]
PAD_LAST, 8'h80, last pad byte driven on control[9:2]
STOP_HOLD, 4, minimum cycles run held low before arming/after stopping (≥3, covers engine's 2-flop run filter)
EXHAUST_SLACK, 8, solution overshoot before budget counts as exhausted (engine pipeline depth)
WDOG_CYCLES, 32'd100_000_000, RUN-state cycle limit (only with MINER_WATCHDOG_EN)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  job accepted when valid&ready
job_header  in  256  header hash
job_difficulty  in  256  target
job_start_nonce  in  64  first nonce
job_nonce_count  in  64  nonce budget; 0 = unbounded
job_test  in  1  equality-match test mode
job_id  in  8  tag echoed in result
abort  in  1  level; stop current job
m_header  out  256  to engine
m_difficulty  out  256  to engine
m_start_nonce  out  64  to engine
m_control  out  18  {PAD_FIRST, PAD_LAST, test, run}
m_solution  in  64  engine solution
m_status  in  3  engine {test, run, irq}
m_irq  in  1  engine match irq
res_valid  out  1  result available
res_ready  in  1  result consumed
res_id  out  8  job tag
res_found  out  1  match found
res_nonce  out  64  solution if found, else last m_solution
res_aborted  out  1  ended by abort
res_timeout  out  1  ended by watchdog (0 without macro)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; m_control run=0, pads=params, test=0; m_header/m_difficulty/m_start_nonce/res_* = 0; res_valid=0; busy=0; counters 0. Output job_ready=1 once in IDLE.
- job_ready = (state==IDLE). No job is accepted while busy or while a result is pending.
- IDLE: on job_valid&job_ready, register all job fields into m_* and local copies → LOAD. The m_* outputs are stable for the whole job.
- LOAD: run=0 for STOP_HOLD cycles, which loads start_nonce into the engine → ARM.
- ARM: run=1. Wait until m_status[1]=1 → RUN.
- RUN, evaluated in priority order each cycle:
  - m_irq → found=1, res_nonce=m_solution (already corrected by the engine) → STOP.
  - abort → aborted=1 → STOP.
  - timeout (macro enabled) → STOP.
  - count≠0 and (m_solution − start_nonce) mod 2^64 ≥ count + EXHAUST_SLACK (65-bit compare, no overflow) → exhausted → STOP.
- abort during LOAD/ARM → STOP with aborted=1, found=0. abort in IDLE/REPORT is ignored.
- STOP: run=0. Stay for ≥STOP_HOLD cycles and until m_status[1]=0 → REPORT.
- REPORT: res_valid=1 with fields stable until res_ready; on res_valid&res_ready → IDLE (job_ready next cycle). res_ready while res_valid=0 is ignored.
- Simultaneous events: irq+abort → found with aborted=0. irq+exhaust → found.
- Nonce wrap: a start near 2^64−1 wraps. The modular difference handles it.
- Back-to-back jobs: minimum run-low gap between jobs = 2·STOP_HOLD cycles.

Optional Feature:
MINER_WATCHDOG_EN:
- Defined: 32-bit counter clears on entry to RUN and increments each RUN cycle. At count == WDOG_CYCLES−1 with no irq/abort → res_timeout=1, → STOP.
- Undefined: no counter; res_timeout tied 0; RUN exits only on irq/abort/exhaust.

Decomposition:
- Package miner_pkg: state encoding (IDLE, LOAD, ARM, RUN, STOP, REPORT); control bit indices (RUN_BIT=0, TEST_BIT=1, PADL 9:2, PADF 17:10); status indices (IRQ=0, RUN=1, TEST=2); default pad bytes.
- One sub-module, miner_nonce_budget: holds start/count and computes the registered exhausted flag from m_solution.

Test Plan:
- Job start=0x100, count=0, behavioural engine raises irq with solution=0x1234 → res_found=1, res_nonce=0x1234, res_id echoed, run low ≥4 cycles before res_valid.
- start=0x10, count=16, no irq → exhaust when m_solution ≥ 0x28; res_found=0, res_nonce ≥ 0x28, m_control[0] falls.
- abort pulsed 1 cycle in ARM → res_aborted=1, res_found=0; abort in IDLE → no effect, job_ready stays 1.
- irq and abort in same RUN cycle → res_found=1, res_aborted=0; start=0xFFFF_FFFF_FFFF_FFFC, count=4 → exhaust after wrap at solution=0x8.
- res_ready held 0 for 50 cycles → res_valid/fields stable, job_ready=0; rst_n asserted mid-RUN → run=0 and res_valid=0 immediately (async), state IDLE.
- With MINER_WATCHDOG_EN, WDOG_CYCLES=100, no irq → res_timeout=1 after exactly 100 RUN cycles; without macro res_timeout never 1.
